// File: rtl/fp_regfile_pkg.sv
// Shared constants, address-width helper and read-source encoding for the FP register file.
package fp_regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 3;

    function automatic int addr_w(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    // Low bit of port p inside a packed multi-port bus of the given field width.
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

    typedef enum logic [1:0] {
        SRC_ARRAY = 2'd0,
        SRC_WA    = 2'd1,
        SRC_WB    = 2'd2
    } rd_src_e;

endpackage

// File: rtl/fp_regfile_mp_if.sv
// Issue/writeback bus of the FP register file; master is the FPU pipeline, slave the register file.
interface fp_regfile_mp_if
    import fp_regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF
);
    localparam int AW = addr_w(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic                iss_busy;
    logic                wa_valid;
    logic [AW-1:0]       wa_addr;
    logic [XLEN-1:0]     wa_data;
    logic                wb_valid;
    logic                wb_ready;
    logic [AW-1:0]       wb_addr;
    logic [XLEN-1:0]     wb_data;
    logic                flush;
    logic [AW:0]         busy_cnt;

    modport master (
        output rd_addr, iss_valid, iss_rd, wa_valid, wa_addr, wa_data,
               wb_valid, wb_addr, wb_data, flush,
        input  rd_data, rd_busy, iss_busy, wb_ready, busy_cnt
    );

    modport slave (
        input  rd_addr, iss_valid, iss_rd, wa_valid, wa_addr, wa_data,
               wb_valid, wb_addr, wb_data, flush,
        output rd_data, rd_busy, iss_busy, wb_ready, busy_cnt
    );

endinterface

// File: rtl/fp_scoreboard.sv
// Per-register busy tracking: issue sets, committed writes clear, flush clears; registered popcount.
module fp_scoreboard
    import fp_regfile_pkg::*;
#(
    parameter  int NREGS = NREGS_DEF,
    localparam int AW    = addr_w(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [AW-1:0]    set_addr,
    input  logic             clr_a_en,
    input  logic [AW-1:0]    clr_a_addr,
    input  logic             clr_b_en,
    input  logic [AW-1:0]    clr_b_addr,
    input  logic             flush,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      busy_cnt
);

    logic [NREGS-1:0] busy_nxt;
    logic [AW:0]      cnt_nxt;

    // A new producer issuing this cycle wins over any clear or flush on the same register.
    always_comb begin
        busy_nxt = busy;
        cnt_nxt  = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (set_en && set_addr == AW'(i)) begin
                busy_nxt[i] = 1'b1;
            end else if ((clr_a_en && clr_a_addr == AW'(i)) ||
                         (clr_b_en && clr_b_addr == AW'(i))) begin
                busy_nxt[i] = 1'b0;
            end else if (flush) begin
                busy_nxt[i] = 1'b0;
            end
            cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/fp_regfile_mp.sv
// Multi-port FP register file with scoreboard; define FP_REGFILE_BYPASS_EN to forward
// same-cycle committed write data onto the read ports.
module fp_regfile_mp
    import fp_regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF
) (
    input logic           clk,
    input logic           rst,
    fp_regfile_mp_if.slave bus
);

    localparam int AW = addr_w(NREGS);

    logic [XLEN-1:0]  freg [NREGS];
    logic [NREGS-1:0] busy;
    logic [AW:0]      busy_cnt;
    logic             wb_ready;
    logic             wb_commit;

    // Port A never stalls; B backs off only when both target the same register.
    assign wb_ready  = !(bus.wa_valid && bus.wa_addr == bus.wb_addr);
    assign wb_commit = bus.wb_valid && wb_ready;

    assign bus.wb_ready = wb_ready;
    assign bus.busy_cnt = busy_cnt;
    assign bus.iss_busy = busy[bus.iss_rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                freg[i] <= '0;
            end
        end else begin
            if (bus.wa_valid) begin
                freg[bus.wa_addr] <= bus.wa_data;
            end
            if (wb_commit) begin
                freg[bus.wb_addr] <= bus.wb_data;
            end
        end
    end

    fp_scoreboard #(.NREGS(NREGS)) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en     (bus.iss_valid),
        .set_addr   (bus.iss_rd),
        .clr_a_en   (bus.wa_valid),
        .clr_a_addr (bus.wa_addr),
        .clr_b_en   (wb_commit),
        .clr_b_addr (bus.wb_addr),
        .flush      (bus.flush),
        .busy       (busy),
        .busy_cnt   (busy_cnt)
    );

    always_comb begin
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] word;
        rd_src_e         src;
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            ra  = bus.rd_addr[slice_lo(i, AW) +: AW];
            src = SRC_ARRAY;
`ifdef FP_REGFILE_BYPASS_EN
            if (bus.wa_valid && bus.wa_addr == ra) begin
                src = SRC_WA;
            end else if (wb_commit && bus.wb_addr == ra) begin
                src = SRC_WB;
            end
`endif
            case (src)
                SRC_WA:  word = bus.wa_data;
                SRC_WB:  word = bus.wb_data;
                default: word = freg[ra];
            endcase
            bus.rd_data[slice_lo(i, XLEN) +: XLEN] = word;
            // A forwarded read already sees the producer's result, so it is not a hazard.
            bus.rd_busy[i] = busy[ra] && (src == SRC_ARRAY);
        end
    end

endmodule

// File: tb/tb_fp_regfile_mp.sv
// Self-checking bench for fp_regfile_mp: directed scenarios plus randomized traffic against a reference model.
module tb_fp_regfile_mp;
    import fp_regfile_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 3;
    localparam int AW    = 5;
`ifdef FP_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

    fp_regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [XLEN-1:0] mreg  [NREGS];
    bit              mbusy [NREGS];

    function automatic bit m_wbr();
        return !(bus.wa_valid && bus.wa_addr == bus.wb_addr);
    endfunction

    function automatic logic [AW-1:0] port_addr(input int p);
        logic [NRD*AW-1:0] v;
        v = bus.rd_addr;
        return v[p*AW +: AW];
    endfunction

    function automatic logic [XLEN-1:0] port_data(input int p);
        logic [NRD*XLEN-1:0] v;
        v = bus.rd_data;
        return v[p*XLEN +: XLEN];
    endfunction

    function automatic logic [XLEN-1:0] exp_rd(input int p);
        logic [AW-1:0] a;
        a = port_addr(p);
        if (BYP && bus.wa_valid && bus.wa_addr == a) return bus.wa_data;
        if (BYP && bus.wb_valid && m_wbr() && bus.wb_addr == a) return bus.wb_data;
        return mreg[a];
    endfunction

    function automatic bit exp_rbusy(input int p);
        logic [AW-1:0] a;
        bit hit;
        a   = port_addr(p);
        hit = (bus.wa_valid && bus.wa_addr == a) || (bus.wb_valid && m_wbr() && bus.wb_addr == a);
        return mbusy[a] && !(BYP && hit);
    endfunction

    function automatic int exp_cnt();
        int c = 0;
        for (int i = 0; i < NREGS; i++) c += int'(mbusy[i]);
        return c;
    endfunction

    task automatic set_rd(input int p, input int a);
        bus.rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic idle();
        bus.iss_valid = 1'b0; bus.iss_rd  = '0;
        bus.wa_valid  = 1'b0; bus.wa_addr = '0; bus.wa_data = '0;
        bus.wb_valid  = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
        bus.flush     = 1'b0;
    endtask

    // Advance the model by one clock edge from the inputs currently applied, then step the DUT.
    task automatic tick();
        bit wbc;
        wbc = bus.wb_valid && m_wbr();
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin mreg[i] = '0; mbusy[i] = 1'b0; end
        end else begin
            if (wbc)          mreg[bus.wb_addr] = bus.wb_data;
            if (bus.wa_valid) mreg[bus.wa_addr] = bus.wa_data;
            if (bus.flush) for (int i = 0; i < NREGS; i++) mbusy[i] = 1'b0;
            if (bus.wa_valid) mbusy[bus.wa_addr] = 1'b0;
            if (wbc)          mbusy[bus.wb_addr] = 1'b0;
            if (bus.iss_valid) mbusy[bus.iss_rd] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        bus.wa_valid = 1'b1; bus.wa_addr = 5; bus.wa_data = 32'h3F800000;
        tick();
        idle(); set_rd(0, 5);
        #1;
        n_cmp++;
        if (port_data(0) !== 32'h3F800000) begin
            n_err++; $display("FAIL reset_prewrite: got %h want %h", port_data(0), 32'h3F800000);
        end
        rst = 1'b1;
        bus.wa_valid = 1'b1; bus.wa_addr = 5; bus.wa_data = 32'hAAAA5555;
        bus.iss_valid = 1'b1; bus.iss_rd = 3;
        tick();
        rst = 1'b0; idle();
        set_rd(0, 5); set_rd(1, 0); set_rd(2, 31);
        #1;
        for (int p = 0; p < NRD; p++) begin
            n_cmp++;
            if (port_data(p) !== 32'h0) begin
                n_err++; $display("FAIL reset_rd_data%0d: got %h want 0", p, port_data(p));
            end
        end
        n_cmp++;
        if (bus.busy_cnt !== 6'd0) begin
            n_err++; $display("FAIL reset_busy_cnt: got %0d want 0", bus.busy_cnt);
        end
        n_cmp++;
        if (bus.wb_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_wb_ready: got %b want 1", bus.wb_ready);
        end
    endtask

    task automatic test_dual_write();
        idle();
        bus.wa_valid = 1'b1; bus.wa_addr = 1; bus.wa_data = 32'h40000000;
        bus.wb_valid = 1'b1; bus.wb_addr = 2; bus.wb_data = 32'h40400000;
        #1;
        n_cmp++;
        if (bus.wb_ready !== 1'b1) begin
            n_err++; $display("FAIL dual_wb_ready: got %b want 1", bus.wb_ready);
        end
        tick();
        idle(); set_rd(0, 1); set_rd(1, 2);
        #1;
        n_cmp++;
        if (port_data(0) !== 32'h40000000) begin
            n_err++; $display("FAIL dual_r1: got %h want %h", port_data(0), 32'h40000000);
        end
        n_cmp++;
        if (port_data(1) !== 32'h40400000) begin
            n_err++; $display("FAIL dual_r2: got %h want %h", port_data(1), 32'h40400000);
        end
    endtask

    task automatic test_collision();
        idle(); set_rd(0, 7);
        bus.wa_valid = 1'b1; bus.wa_addr = 7; bus.wa_data = 32'h11111111;
        bus.wb_valid = 1'b1; bus.wb_addr = 7; bus.wb_data = 32'h22222222;
        #1;
        n_cmp++;
        if (bus.wb_ready !== 1'b0) begin
            n_err++; $display("FAIL coll_wb_ready0: got %b want 0", bus.wb_ready);
        end
        tick();
        bus.wa_valid = 1'b0;
        #1;
        n_cmp++;
        if (mreg[7] !== 32'h11111111 || port_data(0) !== exp_rd(0)) begin
            n_err++; $display("FAIL coll_r7_a: got %h want %h", port_data(0), exp_rd(0));
        end
        n_cmp++;
        if (bus.wb_ready !== 1'b1) begin
            n_err++; $display("FAIL coll_wb_ready1: got %b want 1", bus.wb_ready);
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (port_data(0) !== 32'h22222222) begin
            n_err++; $display("FAIL coll_r7_b: got %h want %h", port_data(0), 32'h22222222);
        end
    endtask

    task automatic test_scoreboard();
        idle(); set_rd(0, 0); set_rd(1, 3); set_rd(2, 4);
        bus.iss_valid = 1'b1; bus.iss_rd = 3;
        tick();
        idle(); bus.iss_rd = 3;
        #1;
        n_cmp++;
        if (bus.busy_cnt !== 6'd1) begin
            n_err++; $display("FAIL sb_cnt_after_iss: got %0d want 1", bus.busy_cnt);
        end
        n_cmp++;
        if (bus.rd_busy !== 3'b010) begin
            n_err++; $display("FAIL sb_rd_busy: got %b want 010", bus.rd_busy);
        end
        n_cmp++;
        if (bus.iss_busy !== 1'b1) begin
            n_err++; $display("FAIL sb_iss_busy: got %b want 1", bus.iss_busy);
        end
        bus.wa_valid = 1'b1; bus.wa_addr = 3; bus.wa_data = 32'h3F000000;
        #1;
        n_cmp++;
        if (bus.rd_busy[1] !== exp_rbusy(1)) begin
            n_err++; $display("FAIL sb_rd_busy_during_wr: got %b want %b", bus.rd_busy[1], exp_rbusy(1));
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (bus.busy_cnt !== 6'd0 || bus.rd_busy !== 3'b000) begin
            n_err++; $display("FAIL sb_cleared: got cnt %0d busy %b want 0 000", bus.busy_cnt, bus.rd_busy);
        end
        bus.iss_valid = 1'b1; bus.iss_rd = 3;
        bus.wa_valid  = 1'b1; bus.wa_addr = 3; bus.wa_data = 32'h3E000000;
        tick();
        idle();
        #1;
        n_cmp++;
        if (bus.busy_cnt !== 6'd1 || bus.rd_busy[1] !== 1'b1) begin
            n_err++; $display("FAIL sb_iss_wins: got cnt %0d busy %b want 1 1", bus.busy_cnt, bus.rd_busy[1]);
        end
        bus.wa_valid = 1'b1; bus.wa_addr = 3; bus.wa_data = 32'h3D000000;
        tick();
        idle();
    endtask

    task automatic test_flush();
        int regs [3] = '{4, 6, 9};
        idle();
        for (int k = 0; k < 3; k++) begin
            bus.iss_valid = 1'b1; bus.iss_rd = AW'(regs[k]);
            tick();
        end
        idle();
        #1;
        n_cmp++;
        if (bus.busy_cnt !== 6'd3) begin
            n_err++; $display("FAIL flush_pre_cnt: got %0d want 3", bus.busy_cnt);
        end
        bus.flush = 1'b1; bus.iss_valid = 1'b1; bus.iss_rd = 10;
        tick();
        idle(); bus.iss_rd = 10;
        #1;
        n_cmp++;
        if (bus.busy_cnt !== 6'd1 || bus.iss_busy !== 1'b1) begin
            n_err++; $display("FAIL flush_cnt: got cnt %0d r10 %b want 1 1", bus.busy_cnt, bus.iss_busy);
        end
        bus.wb_valid = 1'b1; bus.wb_addr = 6; bus.wb_data = 32'h12345678;
        tick();
        idle(); set_rd(0, 6);
        #1;
        n_cmp++;
        if (port_data(0) !== 32'h12345678 || bus.busy_cnt !== 6'd1) begin
            n_err++; $display("FAIL flush_late_wb: got %h cnt %0d want 12345678 1", port_data(0), bus.busy_cnt);
        end
        bus.wa_valid = 1'b1; bus.wa_addr = 10; bus.wa_data = '0;
        tick();
        idle();
    endtask

    task automatic test_bypass();
        idle(); set_rd(0, 8);
        bus.wa_valid = 1'b1; bus.wa_addr = 8; bus.wa_data = 32'hDEADBEEF;
        #1;
        n_cmp++;
        if (port_data(0) !== (BYP ? 32'hDEADBEEF : 32'h0)) begin
            n_err++; $display("FAIL bypass_same_cycle: got %h want %h", port_data(0), BYP ? 32'hDEADBEEF : 32'h0);
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (port_data(0) !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL bypass_next_cycle: got %h want DEADBEEF", port_data(0));
        end
    endtask

    task automatic test_random();
        bit wb_hold = 1'b0;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int p = 0; p < NRD; p++) set_rd(p, $urandom_range(0, 15));
            bus.wa_valid = $urandom_range(0, 1);
            bus.wa_addr  = AW'($urandom_range(0, 15));
            bus.wa_data  = $urandom;
            if (!wb_hold) begin
                bus.wb_valid = ($urandom_range(0, 2) != 0);
                bus.wb_addr  = AW'($urandom_range(0, 15));
                bus.wb_data  = $urandom;
            end
            bus.iss_rd    = AW'($urandom_range(0, 15));
            bus.iss_valid = ($urandom_range(0, 2) == 0) && !mbusy[bus.iss_rd];
            bus.flush     = ($urandom_range(0, 15) == 0);
            #1;
            n_cmp++;
            if (bus.wb_ready !== m_wbr()) begin
                n_err++; $display("FAIL rnd_wb_ready c%0d: got %b want %b", c, bus.wb_ready, m_wbr());
            end
            for (int p = 0; p < NRD; p++) begin
                n_cmp++;
                if (port_data(p) !== exp_rd(p)) begin
                    n_err++; $display("FAIL rnd_rd_data%0d c%0d: got %h want %h", p, c, port_data(p), exp_rd(p));
                end
                n_cmp++;
                if (bus.rd_busy[p] !== exp_rbusy(p)) begin
                    n_err++; $display("FAIL rnd_rd_busy%0d c%0d: got %b want %b", p, c, bus.rd_busy[p], exp_rbusy(p));
                end
            end
            n_cmp++;
            if (bus.iss_busy !== mbusy[bus.iss_rd]) begin
                n_err++; $display("FAIL rnd_iss_busy c%0d: got %b want %b", c, bus.iss_busy, mbusy[bus.iss_rd]);
            end
            n_cmp++;
            if (int'(bus.busy_cnt) != exp_cnt()) begin
                n_err++; $display("FAIL rnd_busy_cnt c%0d: got %0d want %0d", c, bus.busy_cnt, exp_cnt());
            end
            wb_hold = !rst && bus.wb_valid && !m_wbr();
            tick();
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        bus.rd_addr = '0;
        idle();
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_dual_write();
        test_collision();
        test_scoreboard();
        test_flush();
        test_bypass();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
